weight_fetch_ctrl: RTL

Sequencer for the kernel weight ROM reader. On a layer start it walks every (out_ch, in_ch) pair of the layer, issues one kernel fetch per pair to the weight memory reader, collects the KERNEL_SIZE streamed weights into a packed kernel word, and hands each complete kernel to the PE array over a valid/ready handshake. It sits between the layer controller and the weight memory reader.

---
 rtl/weight_fetch_ctrl_pkg.sv | 24 ++
 rtl/weight_fetch_ctrl_packer.sv | 55 +++++
 rtl/weight_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/weight_fetch_ctrl_pkg.sv
// ============================================================================
// weight_fetch_ctrl_pkg : shared types and defaults for the weight fetch sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package weight_fetch_ctrl_pkg;

  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int DEF_KERNEL_SIZE  = 9;
  localparam int DEF_CH_WIDTH     = 8;
  localparam int MAX_CH_NUM       = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_DONE    = 3'd4
  } wfc_state_e;

endpackage

`default_nettype wire

// File: rtl/weight_fetch_ctrl_packer.sv
// ============================================================================
// weight_kernel_packer : counts streamed weight beats and drops each into its slot
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_kernel_packer #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int KERNEL_SIZE  = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              wr_en,
  input  logic [WEIGHT_WIDTH-1:0]           wr_data,
  output logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] kern_data,
  output logic                              last_beat
);

  localparam int BEAT_W = $clog2(KERNEL_SIZE + 1);

  logic [BEAT_W-1:0]                    beat_q, beat_d;
  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0]  data_q, data_d;

  always_comb begin
    beat_d = beat_q;
    data_d = data_q;
    if (clear) begin
      beat_d = '0;
    end else if (wr_en) begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        if (beat_q == BEAT_W'(k)) begin
          data_d[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wr_data;
        end
      end
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      data_q <= '0;
    end else begin
      beat_q <= beat_d;
      data_q <= data_d;
    end
  end

  assign kern_data = data_q;
  assign last_beat = wr_en && (beat_q == BEAT_W'(KERNEL_SIZE - 1));

endmodule

`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
// ============================================================================
// weight_fetch_ctrl : walks (out_ch, in_ch) pairs, fetches and packs each kernel
// Optional: WFC_STALL_CNT_EN adds stat_stall_cycles back-pressure counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int CH_WIDTH     = DEF_CH_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic [CH_WIDTH-1:0]                 cfg_in_ch_num,
  input  logic [CH_WIDTH-1:0]                 cfg_out_ch_num,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_start,
  output logic [CH_WIDTH-1:0]                 mem_in_ch,
  output logic [CH_WIDTH-1:0]                 mem_out_ch,
  input  logic [WEIGHT_WIDTH-1:0]             mem_weight,
  input  logic                                mem_valid,
  output logic                                mem_ready,
  output logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] kern_data,
  output logic [CH_WIDTH-1:0]                 kern_in_ch,
  output logic [CH_WIDTH-1:0]                 kern_out_ch,
  output logic                                kern_last,
  output logic                                kern_valid,
  input  logic                                kern_ready
`ifdef WFC_STALL_CNT_EN
  ,
  output logic [31:0]                         stat_stall_cycles
`endif
);

  wfc_state_e          state_q, state_d;
  logic [CH_WIDTH-1:0] in_num_q, in_num_d, out_num_q, out_num_d;
  logic [CH_WIDTH-1:0] ic_q, ic_d, oc_q, oc_d;
  logic [CH_WIDTH-1:0] mem_in_ch_q, mem_in_ch_d, mem_out_ch_q, mem_out_ch_d;
  logic [CH_WIDTH-1:0] kern_in_ch_q, kern_in_ch_d, kern_out_ch_q, kern_out_ch_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                mem_start_q, mem_start_d, mem_ready_q, mem_ready_d;
  logic                kern_valid_q, kern_valid_d, kern_last_q, kern_last_d;

  logic                ic_wrap, at_last_pair;
  logic [CH_WIDTH-1:0] ic_next, oc_next;
  logic                pack_clear, pack_wr_en, pack_last;

  assign ic_wrap      = (ic_q == in_num_q - CH_WIDTH'(1));
  assign at_last_pair = ic_wrap && (oc_q == out_num_q - CH_WIDTH'(1));
  assign ic_next      = ic_wrap ? '0 : ic_q + CH_WIDTH'(1);
  assign oc_next      = ic_wrap ? oc_q + CH_WIDTH'(1) : oc_q;

  // Beat counter restarts while the fetch request is on the bus.
  assign pack_clear = (state_q == ST_ISSUE);
  assign pack_wr_en = mem_valid && mem_ready_q;

  weight_kernel_packer #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .KERNEL_SIZE  (KERNEL_SIZE)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .wr_en     (pack_wr_en),
    .wr_data   (mem_weight),
    .kern_data (kern_data),
    .last_beat (pack_last)
  );

  always_comb begin
    state_d       = state_q;
    in_num_d      = in_num_q;
    out_num_d     = out_num_q;
    ic_d          = ic_q;
    oc_d          = oc_q;
    mem_in_ch_d   = mem_in_ch_q;
    mem_out_ch_d  = mem_out_ch_q;
    kern_in_ch_d  = kern_in_ch_q;
    kern_out_ch_d = kern_out_ch_q;
    kern_last_d   = kern_last_q;
    done_d        = 1'b0;
    mem_start_d   = 1'b0;
    mem_ready_d   = 1'b0;
    kern_valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          in_num_d     = cfg_in_ch_num;
          out_num_d    = cfg_out_ch_num;
          ic_d         = '0;
          oc_d         = '0;
          mem_in_ch_d  = '0;
          mem_out_ch_d = '0;
          if (cfg_in_ch_num == '0 || cfg_out_ch_num == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            mem_start_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d     = ST_COLLECT;
        mem_ready_d = 1'b1;
      end
      ST_COLLECT: begin
        if (pack_last) begin
          state_d       = ST_OUTPUT;
          kern_valid_d  = 1'b1;
          kern_in_ch_d  = ic_q;
          kern_out_ch_d = oc_q;
          kern_last_d   = at_last_pair;
        end else begin
          mem_ready_d = 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (kern_ready) begin
          kern_last_d = 1'b0;
          if (kern_last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            mem_start_d  = 1'b1;
            ic_d         = ic_next;
            oc_d         = oc_next;
            mem_in_ch_d  = ic_next;
            mem_out_ch_d = oc_next;
          end
        end else begin
          kern_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      in_num_q      <= '0;
      out_num_q     <= '0;
      ic_q          <= '0;
      oc_q          <= '0;
      mem_in_ch_q   <= '0;
      mem_out_ch_q  <= '0;
      kern_in_ch_q  <= '0;
      kern_out_ch_q <= '0;
      kern_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_start_q   <= 1'b0;
      mem_ready_q   <= 1'b0;
      kern_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_num_q      <= in_num_d;
      out_num_q     <= out_num_d;
      ic_q          <= ic_d;
      oc_q          <= oc_d;
      mem_in_ch_q   <= mem_in_ch_d;
      mem_out_ch_q  <= mem_out_ch_d;
      kern_in_ch_q  <= kern_in_ch_d;
      kern_out_ch_q <= kern_out_ch_d;
      kern_last_q   <= kern_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_start_q   <= mem_start_d;
      mem_ready_q   <= mem_ready_d;
      kern_valid_q  <= kern_valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_start   = mem_start_q;
  assign mem_in_ch   = mem_in_ch_q;
  assign mem_out_ch  = mem_out_ch_q;
  assign mem_ready   = mem_ready_q;
  assign kern_in_ch  = kern_in_ch_q;
  assign kern_out_ch = kern_out_ch_q;
  assign kern_last   = kern_last_q;
  assign kern_valid  = kern_valid_q;

`ifdef WFC_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == ST_IDLE && cfg_start) begin
      stall_cnt_d = '0;
    end else if (kern_valid_q && !kern_ready && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule

`default_nettype wire
